fp_vmult_sched: RTL and testbench

- Shares one pipelined fp_vector_mult instance among NUM_REQ requesters.
- Round-robin arbiter issues at most one vector-pair per cycle.
- Each in-flight op is tagged with its requester ID in a LATENCY-deep tag pipe. Results are buffered in a result FIFO and returned with a valid/ready handshake.
- The multiplier cannot stall, so issue is credit-limited to guarantee FIFO space for every in-flight result.

---
 rtl/fp_vmult_sched_pkg.sv | 31 +++
 rtl/fp_vmult_result_fifo.sv | 65 ++++++
 rtl/fp_vmult_sched.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_fp_vmult_sched.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_vmult_sched_pkg.sv
// -----------------------------------------------------------------------------
// fp_vmult_sched_pkg
// Shared types and default configuration for the vector-multiplier scheduler.
//   state_e : scheduler FSM states (RUN, DRAIN, DONE)
//   tag_t   : in-flight tag {valid, id} for the default requester count
//   ID_W    : requester-id width for the default configuration
//   VEC_W   : packed vector width for the default configuration
// -----------------------------------------------------------------------------
package fp_vmult_sched_pkg;

    localparam int WIDTH_DEF      = 32;
    localparam int NUM_INPUTS_DEF = 5;
    localparam int LATENCY_DEF    = 8;
    localparam int NUM_REQ_DEF    = 4;
    localparam int FIFO_DEPTH_DEF = 16;

    localparam int ID_W  = $clog2(NUM_REQ_DEF);
    localparam int VEC_W = WIDTH_DEF * NUM_INPUTS_DEF;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/fp_vmult_result_fifo.sv
// -----------------------------------------------------------------------------
// fp_vmult_result_fifo
// Synchronous show-ahead FIFO holding {id, data} results. The head entry is
// visible on head_data whenever empty is low; pop consumes it.
//   clk, rst   : clock, asynchronous active-high reset (pointers only)
//   push       : write push_data (ignored when full)
//   push_data  : entry to write
//   pop        : discard head entry (ignored when empty)
//   full/empty : status, from pointer compare with an extra wrap bit
//   head_data  : current head entry
// -----------------------------------------------------------------------------
module fp_vmult_result_fifo
    import fp_vmult_sched_pkg::*;
#(
    parameter int DATA_W = 162,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head_data
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_r;
    logic [AW:0]       rd_ptr_r;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic              do_push_s;
    logic              do_pop_s;

    // Same index with different wrap bit means the write side lapped the read side.
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign head_data = mem_r[rd_ptr_r[AW-1:0]];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

    // Read/write pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/fp_vmult_sched.sv
// -----------------------------------------------------------------------------
// fp_vmult_sched
// Shares one pipelined, non-stallable vector multiplier among NUM_REQ
// requesters. A round-robin arbiter issues at most one operand pair per cycle;
// each issued op carries its requester id down a LATENCY-deep tag pipe, and
// the result is pushed into a show-ahead result FIFO returned by valid/ready.
// Issue is credit-limited so every in-flight result has a FIFO slot waiting.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid/req_ready : per-requester request / one-hot grant
//   req_a, req_b        : operands, requester i at slice i
//   mult_a/b, mult_ready: operands and one-cycle issue strobe to multiplier
//   mult_o, mult_valid  : multiplier result and its valid
//   resp_valid/id/data  : FIFO head; popped when resp_ready[resp_id] is high
//   flush / flush_done  : drain request / one-cycle done pulse
//   err                 : sticky tag-vs-mult_valid mismatch
//
// Optional build macro FP_VMULT_SCHED_STATS_EN adds stat_issued and
// stat_stalled saturating 32-bit counters.
// -----------------------------------------------------------------------------
module fp_vmult_sched
    import fp_vmult_sched_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NUM_INPUTS = 5,
    parameter int LATENCY    = 8,
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ*WIDTH*NUM_INPUTS-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH*NUM_INPUTS-1:0]   req_b,
    output logic [NUM_REQ-1:0]                    req_ready,
    output logic [WIDTH*NUM_INPUTS-1:0]           mult_a,
    output logic [WIDTH*NUM_INPUTS-1:0]           mult_b,
    output logic                                  mult_ready,
    input  logic [WIDTH*NUM_INPUTS-1:0]           mult_o,
    input  logic                                  mult_valid,
    output logic                                  resp_valid,
    output logic [$clog2(NUM_REQ)-1:0]            resp_id,
    output logic [WIDTH*NUM_INPUTS-1:0]           resp_data,
    input  logic [NUM_REQ-1:0]                    resp_ready,
    input  logic                                  flush,
    output logic                                  flush_done,
`ifdef FP_VMULT_SCHED_STATS_EN
    output logic [31:0]                           stat_issued,
    output logic [31:0]                           stat_stalled,
`endif
    output logic                                  err
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int VW  = WIDTH * NUM_INPUTS;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    state_e               state_r;
    state_e               state_next_s;
    logic                 flush_hold_r;
    logic [IDW-1:0]       rr_ptr_r;
    logic [CW-1:0]        credits_r;

    logic                 grant_found_s;
    logic [IDW-1:0]       grant_id_s;
    logic [NUM_REQ-1:0]   grant_oh_s;
    logic                 accept_s;
    logic [VW-1:0]        sel_a_s;
    logic [VW-1:0]        sel_b_s;

    logic [VW-1:0]        mult_a_r;
    logic [VW-1:0]        mult_b_r;
    logic                 mult_ready_r;
    logic [IDW-1:0]       issue_id_r;

    logic [LATENCY-1:0]   tag_v_r;
    logic [IDW-1:0]       tag_id_r [LATENCY];
    logic                 tag_exit_v_s;
    logic                 pipe_empty_s;

    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [IDW+VW-1:0]    fifo_head_s;
    logic [IDW-1:0]       head_id_s;
    logic                 pop_s;
    logic                 err_r;
    logic                 flush_done_s;

    // Round-robin search: first valid requester at or after the pointer, wrapping.
    always_comb begin
        grant_found_s = 1'b0;
        grant_id_s    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int             idx_v;
            logic [IDW-1:0] cand_v;
            idx_v = int'(rr_ptr_r) + k;
            if (idx_v >= NUM_REQ) begin
                idx_v = idx_v - NUM_REQ;
            end else begin
                idx_v = idx_v;
            end
            cand_v = IDW'(idx_v);
            if (!grant_found_s && req_valid[cand_v]) begin
                grant_found_s = 1'b1;
                grant_id_s    = cand_v;
            end else begin
                grant_id_s    = grant_id_s;
            end
        end
    end

    assign accept_s = grant_found_s && (state_r == RUN) && (credits_r != {CW{1'b0}});

    // One-hot grant and operand select for the winning requester.
    always_comb begin
        grant_oh_s = '0;
        sel_a_s    = '0;
        sel_b_s    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_id_s == IDW'(k)) begin
                sel_a_s = req_a[k*VW +: VW];
                sel_b_s = req_b[k*VW +: VW];
            end else begin
                sel_a_s = sel_a_s;
            end
        end
        if (accept_s) begin
            grant_oh_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_s;
        end else begin
            grant_oh_s = '0;
        end
    end

    assign req_ready = grant_oh_s;

    // Issue register: operands and strobe go to the multiplier the cycle after accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mult_a_r     <= '0;
            mult_b_r     <= '0;
            mult_ready_r <= 1'b0;
            issue_id_r   <= '0;
        end else begin
            mult_ready_r <= accept_s;
            if (accept_s) begin
                mult_a_r   <= sel_a_s;
                mult_b_r   <= sel_b_s;
                issue_id_r <= grant_id_s;
            end
        end
    end

    assign mult_a     = mult_a_r;
    assign mult_b     = mult_b_r;
    assign mult_ready = mult_ready_r;

    // Tag pipe: the issue-cycle tag lands at the last stage exactly when mult_valid is due.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v_r <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_id_r[i] <= '0;
            end
        end else begin
            tag_v_r     <= {tag_v_r[LATENCY-2:0], mult_ready_r};
            tag_id_r[0] <= issue_id_r;
            for (int i = 1; i < LATENCY; i++) begin
                tag_id_r[i] <= tag_id_r[i-1];
            end
        end
    end

    assign tag_exit_v_s = tag_v_r[LATENCY-1];
    assign pipe_empty_s = !mult_ready_r && (tag_v_r == {LATENCY{1'b0}});

    fp_vmult_result_fifo #(
        .DATA_W (IDW + VW),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tag_exit_v_s),
        .push_data ({tag_id_r[LATENCY-1], mult_o}),
        .pop       (pop_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .head_data (fifo_head_s)
    );

    assign head_id_s  = fifo_head_s[VW +: IDW];
    // Only the owner of the head result may consume it.
    assign pop_s      = !fifo_empty_s && resp_ready[head_id_s];
    assign resp_valid = !fifo_empty_s;
    // Head fields are forced to zero when empty so stale storage never shows.
    assign resp_id    = fifo_empty_s ? {IDW{1'b0}} : head_id_s;
    assign resp_data  = fifo_empty_s ? {VW{1'b0}} : fifo_head_s[VW-1:0];

    // Credits track free FIFO slots not already promised to an in-flight op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_r <= CW'(FIFO_DEPTH);
        end else begin
            case ({accept_s, pop_s})
                2'b10:   credits_r <= credits_r - {{(CW-1){1'b0}}, 1'b1};
                2'b01:   credits_r <= credits_r + {{(CW-1){1'b0}}, 1'b1};
                default: credits_r <= credits_r;
            endcase
        end
    end

    // Round-robin pointer moves just past the accepted requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r <= '0;
        end else if (accept_s) begin
            rr_ptr_r <= (grant_id_s == IDW'(NUM_REQ-1)) ? {IDW{1'b0}} : grant_id_s + {{(IDW-1){1'b0}}, 1'b1};
        end
    end

    // Sticky mismatch between multiplier valid and the tag leaving the pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (mult_valid != tag_exit_v_s) begin
            err_r <= 1'b1;
        end
    end

    assign err = err_r;

    // FSM state register plus the flush-hold flag that blocks re-entry while flush stays high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= RUN;
            flush_hold_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (state_r == DONE) begin
                flush_hold_r <= 1'b1;
            end else if (!flush) begin
                flush_hold_r <= 1'b0;
            end
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            RUN: begin
                if (flush && !flush_hold_r) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = RUN;
                end
            end
            DRAIN: begin
                if (pipe_empty_s && fifo_empty_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            DONE:    state_next_s = RUN;
            default: state_next_s = RUN;
        endcase
    end

    // FSM output logic.
    always_comb begin
        flush_done_s = 1'b0;
        case (state_r)
            DONE:    flush_done_s = 1'b1;
            default: flush_done_s = 1'b0;
        endcase
    end

    assign flush_done = flush_done_s;

`ifdef FP_VMULT_SCHED_STATS_EN
    logic [31:0] stat_issued_r;
    logic [31:0] stat_stalled_r;

    // Saturating issue and credit-stall counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued_r  <= 32'd0;
            stat_stalled_r <= 32'd0;
        end else begin
            if (accept_s && (stat_issued_r != 32'hFFFF_FFFF)) begin
                stat_issued_r <= stat_issued_r + 32'd1;
            end
            if ((|req_valid) && (state_r == RUN) && (credits_r == {CW{1'b0}}) &&
                (stat_stalled_r != 32'hFFFF_FFFF)) begin
                stat_stalled_r <= stat_stalled_r + 32'd1;
            end
        end
    end

    assign stat_issued  = stat_issued_r;
    assign stat_stalled = stat_stalled_r;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fp_vmult_sched.sv
module tb_fp_vmult_sched;

    localparam int WIDTH      = 32;
    localparam int NUM_INPUTS = 5;
    localparam int LATENCY    = 8;
    localparam int NUM_REQ    = 4;
    localparam int FIFO_DEPTH = 16;
    localparam int VW         = WIDTH * NUM_INPUTS;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*VW-1:0]   req_a;
    logic [NUM_REQ*VW-1:0]   req_b;
    logic [NUM_REQ-1:0]      req_ready;
    logic [VW-1:0]           mult_a;
    logic [VW-1:0]           mult_b;
    logic                    mult_ready;
    logic [VW-1:0]           mult_o;
    logic                    mult_valid;
    logic                    resp_valid;
    logic [1:0]              resp_id;
    logic [VW-1:0]           resp_data;
    logic [NUM_REQ-1:0]      resp_ready;
    logic                    flush;
    logic                    flush_done;
    logic                    err;
`ifdef FP_VMULT_SCHED_STATS_EN
    logic [31:0]             stat_issued;
    logic [31:0]             stat_stalled;
`endif

    logic                    inject;
    logic [LATENCY-1:0]      mpv;
    logic [VW-1:0]           mpd [LATENCY];
    logic [31:0]             fv [4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fp_vmult_sched #(
        .WIDTH(WIDTH), .NUM_INPUTS(NUM_INPUTS), .LATENCY(LATENCY),
        .NUM_REQ(NUM_REQ), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mult_a(mult_a), .mult_b(mult_b), .mult_ready(mult_ready),
        .mult_o(mult_o), .mult_valid(mult_valid),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
        .resp_ready(resp_ready), .flush(flush), .flush_done(flush_done),
`ifdef FP_VMULT_SCHED_STATS_EN
        .stat_issued(stat_issued), .stat_stalled(stat_stalled),
`endif
        .err(err)
    );

    // Single-precision multiply for normal operands, mantissa truncated.
    function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
        logic [47:0] m;
        logic [9:0]  e;
        logic [31:0] r;
        if (x[30:0] == 31'd0 || y[30:0] == 31'd0) begin
            r = {x[31] ^ y[31], 31'd0};
        end else begin
            m = {1'b1, x[22:0]} * {1'b1, y[22:0]};
            e = {2'b00, x[30:23]} + {2'b00, y[30:23]} - 10'd127;
            if (m[47]) r = {x[31] ^ y[31], e[7:0] + 8'd1, m[46:24]};
            else       r = {x[31] ^ y[31], e[7:0], m[45:23]};
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] vmul(input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [VW-1:0] r;
        for (int j = 0; j < NUM_INPUTS; j++) r[j*32 +: 32] = fmul(a[j*32 +: 32], b[j*32 +: 32]);
        return r;
    endfunction

    // Behavioural fixed-latency multiplier.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mpv <= '0;
            for (int i = 0; i < LATENCY; i++) mpd[i] <= '0;
        end else begin
            mpv    <= {mpv[LATENCY-2:0], mult_ready};
            mpd[0] <= vmul(mult_a, mult_b);
            for (int i = 1; i < LATENCY; i++) mpd[i] <= mpd[i-1];
        end
    end

    assign mult_valid = mpv[LATENCY-1] | inject;
    assign mult_o     = mpd[LATENCY-1];

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; resp_ready = '0; flush = 1'b0; inject = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; resp_ready = '0; flush = 1'b0; inject = 1'b0;
        req_a = '0; req_b = '0;
        @(negedge clk);
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        total++; if (mult_ready !== 1'b0) begin bad++; $display("FAIL reset_mult_ready: got %b want 0", mult_ready); end
        total++; if (mult_a !== {VW{1'b0}} || mult_b !== {VW{1'b0}}) begin bad++; $display("FAIL reset_mult_ab: got %h/%h want 0", mult_a, mult_b); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        total++; if (resp_id !== 2'd0 || resp_data !== {VW{1'b0}}) begin bad++; $display("FAIL reset_resp: got %0d/%h want 0", resp_id, resp_data); end
        total++; if (flush_done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_done_err: got %b/%b want 0/0", flush_done, err); end
`ifdef FP_VMULT_SCHED_STATS_EN
        total++; if (stat_issued !== 32'd0 || stat_stalled !== 32'd0) begin bad++; $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_issued, stat_stalled); end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [VW-1:0] exp_a;
        logic [VW-1:0] exp_b;
        logic [VW-1:0] exp_r;
        int lat;
        exp_a = {32'h40A00000, 32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        exp_b = {5{32'h40000000}};
        exp_r = {32'h41200000, 32'h41000000, 32'h40C00000, 32'h40800000, 32'h40000000};
        req_a[0 +: VW] = exp_a; req_b[0 +: VW] = exp_b;
        req_valid = 4'b0001;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_grant: got %b want 0001", req_ready); end
        lat = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid = '0;
                total++; if (mult_ready !== 1'b1) begin bad++; $display("FAIL single_strobe: got %b want 1", mult_ready); end
                total++; if (mult_a !== exp_a || mult_b !== exp_b) begin bad++; $display("FAIL single_operands: got %h want %h", mult_a, exp_a); end
            end
            if (c == 2) begin
                total++; if (mult_ready !== 1'b0) begin bad++; $display("FAIL single_strobe_len: got %b want 0", mult_ready); end
            end
            if (resp_valid) begin lat = c; break; end
        end
        total++; if (lat != LATENCY + 2) begin bad++; $display("FAIL single_latency: got %0d want %0d", lat, LATENCY + 2); end
        total++; if (resp_id !== 2'd0) begin bad++; $display("FAIL single_id: got %0d want 0", resp_id); end
        total++; if (resp_data !== exp_r) begin bad++; $display("FAIL single_data: got %h want %h", resp_data, exp_r); end
        resp_ready = 4'b0010;
        @(negedge clk);
        total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL single_foreign_ready: got %b want 1", resp_valid); end
        resp_ready = 4'b0001;
        @(negedge clk);
        resp_ready = '0;
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL single_pop: got %b want 0", resp_valid); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL single_err: got %b want 0", err); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_oh;
        int n;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i*VW +: VW] = {NUM_INPUTS{fv[i]}};
            req_b[i*VW +: VW] = {NUM_INPUTS{32'h3F800000}};
        end
        resp_ready = 4'b1111;
        req_valid  = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_oh = 4'b0001 << (k % 4);
            total++; if (req_ready !== exp_oh) begin bad++; $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, exp_oh); end
            @(negedge clk);
        end
        req_valid = '0;
        n = 0;
        for (int c = 0; c < 40 && n < 8; c++) begin
            if (resp_valid) begin
                total++; if (resp_id !== 2'(n % 4)) begin bad++; $display("FAIL rr_resp_id%0d: got %0d want %0d", n, resp_id, n % 4); end
                total++; if (resp_data !== {NUM_INPUTS{fv[n % 4]}}) begin bad++; $display("FAIL rr_resp_data%0d: got %h want %h", n, resp_data, {NUM_INPUTS{fv[n % 4]}}); end
                n++;
            end
            @(negedge clk);
        end
        total++; if (n != 8) begin bad++; $display("FAIL rr_resp_count: got %0d want 8", n); end
        resp_ready = '0;
    endtask

    task automatic test_backpressure();
        int acc;
        int blk;
        int acc2;
        int n;
        do_reset();
        req_a[0 +: VW] = {NUM_INPUTS{32'h40400000}};
        req_b[0 +: VW] = {NUM_INPUTS{32'h3F800000}};
        resp_ready = '0;
        req_valid  = 4'b0001;
        acc = 0; blk = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (req_ready[0]) acc++; else blk++;
            @(negedge clk);
        end
        #1;
        total++; if (acc != 16) begin bad++; $display("FAIL bp_accepts: got %0d want 16", acc); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_blocked: got %b want 0000", req_ready); end
`ifdef FP_VMULT_SCHED_STATS_EN
        total++; if (stat_issued !== 32'd16) begin bad++; $display("FAIL bp_stat_issued: got %0d want 16", stat_issued); end
        total++; if (stat_stalled !== 32'(blk)) begin bad++; $display("FAIL bp_stat_stalled: got %0d want %0d", stat_stalled, blk); end
`endif
        resp_ready = 4'b0001;
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_pop_cycle: got %b want 0000", req_ready); end
        @(negedge clk);
        resp_ready = '0;
        acc2 = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (req_ready[0]) acc2++;
            @(negedge clk);
        end
        total++; if (acc2 != 1) begin bad++; $display("FAIL bp_after_pop: got %0d want 1", acc2); end
`ifdef FP_VMULT_SCHED_STATS_EN
        total++; if (stat_issued !== 32'd17) begin bad++; $display("FAIL bp_stat_issued2: got %0d want 17", stat_issued); end
`endif
        req_valid  = '0;
        resp_ready = 4'b1111;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (resp_valid) n++;
            @(negedge clk);
        end
        total++; if (n != 16) begin bad++; $display("FAIL bp_drain_count: got %0d want 16", n); end
        resp_ready = '0;
    endtask

    task automatic test_flush();
        int  pops;
        int  done_cnt;
        bit  done_seen;
        bit  post_checked;
        do_reset();
        req_a[0 +: VW] = {NUM_INPUTS{32'h40000000}};
        req_b[0 +: VW] = {NUM_INPUTS{32'h3F800000}};
        req_valid = 4'b0001;
        repeat (8) @(negedge clk);
        req_valid = '0;
        repeat (4) @(negedge clk);
        total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL flush_fifo_loaded: got %b want 1", resp_valid); end
        flush = 1'b1;
        resp_ready = 4'b1111;
        pops = 1;
        @(negedge clk);
        req_valid = 4'b0001;
        done_cnt = 0; done_seen = 1'b0; post_checked = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!done_seen) begin
                total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL flush_no_grant: got %b want 0000", req_ready); end
                if (resp_valid) pops++;
                if (flush_done) begin
                    done_seen = 1'b1;
                    done_cnt++;
                    total++; if (pops != 8) begin bad++; $display("FAIL flush_pops_at_done: got %0d want 8", pops); end
                end
            end else begin
                if (flush_done) done_cnt++;
                if (!post_checked) begin
                    post_checked = 1'b1;
                    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL flush_resume: got %b want 0001", req_ready); end
                    req_valid = '0;
                end
            end
            @(negedge clk);
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL flush_done_count: got %0d want 1", done_cnt); end
        flush = 1'b0;
        resp_ready = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_err_reset();
        int stale;
        do_reset();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_initial: got %b want 0", err); end
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", err); end
        repeat (3) @(negedge clk);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", err); end
        req_a[VW +: VW] = {NUM_INPUTS{32'h40800000}};
        req_b[VW +: VW] = {NUM_INPUTS{32'h3F800000}};
        req_valid = 4'b0010;
        repeat (3) @(negedge clk);
        req_valid = '0;
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++; if (mult_ready !== 1'b0 || mult_a !== {VW{1'b0}} || mult_b !== {VW{1'b0}}) begin bad++; $display("FAIL rst_mid_mult: got %b %h want 0", mult_ready, mult_a); end
        total++; if (resp_valid !== 1'b0 || resp_id !== 2'd0 || resp_data !== {VW{1'b0}}) begin bad++; $display("FAIL rst_mid_resp: got %b %0d %h want 0", resp_valid, resp_id, resp_data); end
        total++; if (err !== 1'b0 || flush_done !== 1'b0 || req_ready !== 4'b0000) begin bad++; $display("FAIL rst_mid_misc: got %b %b %b want 0", err, flush_done, req_ready); end
        @(negedge clk);
        rst = 1'b0;
        stale = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (resp_valid) stale++;
        end
        total++; if (stale != 0) begin bad++; $display("FAIL rst_stale_resp: got %0d want 0", stale); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err_clear: got %b want 0", err); end
    endtask

    initial begin
        fv[0] = 32'h3F800000;
        fv[1] = 32'h40000000;
        fv[2] = 32'h40400000;
        fv[3] = 32'h40800000;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_err_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
